ysyx_22041071_axi_rd_arbiter: RTL and testbench
===============================================

YSYX_22041071_AXI_RD_ARBITER -- requirements
Module: ysyx_22041071_axi_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 64, request address width.
REQ-002 SHALL have parameter DATA_W, 64, read data width.
REQ-003 SHALL have parameter LEN_W, 8, AXI burst length width (beats-1).
REQ-004 SHALL use clk, a rising-edge clock; reset reset_n, synchronous, active-low.
REQ-005 SHALL have ports: clk  in  1  clock; reset_n  in  1  sync active-low reset.
REQ-006 SHALL have ports mN_req_valid  in  1 / mN_req_ready  out  1  request handshake, N=0 (ifetch), N=1 (load).
REQ-007 SHALL have ports mN_addr  in  ADDR_W, mN_len  in  LEN_W, mN_size  in  2 (00:1B..11:8B)  request fields.
REQ-008 SHALL have ports mN_rsp_valid  out  1, mN_rsp_data  out  DATA_W, mN_rsp_resp  out  2, mN_rsp_last  out  1  per-beat response.
REQ-009 SHALL have port m0_kill  in  1  discards remaining beats of an m0-owned burst.
REQ-010 SHALL have ports ds_ar_valid  out  1, ds_ar_ready  in  1, ds_id  out  4, ds_addr  out  ADDR_W, ds_len  out  LEN_W, ds_size  out  2  downstream read-address side.
REQ-011 SHALL have ports ds_r_valid  in  1, ds_r_data  in  DATA_W, ds_r_resp  in  2, ds_r_last  in  1  downstream read-data side.

Function
REQ-012 SHALL implement FSM IDLE, ISSUE, DATA; one outstanding burst at a time.
REQ-013 IDLE: on any mN_req_valid, grant one requester, assert its mN_req_ready combinationally that cycle, latch addr/len/size, set owner, go ISSUE.
REQ-014 Both valid in IDLE: grant the requester not granted last (last_grant register); single valid: grant it regardless.
REQ-015 ISSUE: ds_ar_valid=1 with latched fields stable; ds_id = owner (0 or 1, zero-extended); on ds_ar_ready go DATA.
REQ-016 Latency: request accepted at edge N -> ds_ar_valid high from cycle N+1.
REQ-017 DATA: each ds_r_valid beat forwarded combinationally to owner's rsp_* (same cycle); non-owner rsp_valid=0, rsp_data=0, rsp_resp=0, rsp_last=0.
REQ-018 DATA: ds_r_valid && ds_r_last -> IDLE; no grant in that cycle (one-cycle bubble minimum between bursts).
REQ-019 m0_kill while owner=0 in ISSUE or DATA sets kill flag; remaining beats consumed, m0_rsp_valid suppressed; flag cleared on return to IDLE.
REQ-020 m0_kill in IDLE or while owner=1 SHALL have no effect.
REQ-021 ds_r_valid outside DATA SHALL be ignored.
REQ-022 mN_req_ready SHALL be 0 in ISSUE and DATA.

Reset
REQ-023 On reset: state IDLE, ds_ar_valid=0, ds_id/ds_addr/ds_len/ds_size=0, owner=0, kill flag=0, last_grant=1 (m0 wins first tie).
REQ-024 Reset mid-burst SHALL abandon the burst; no rsp_valid after the reset edge.

Configuration
REQ-025 YSYX_22041071_ARB_PERF_EN defined: SHALL add outputs perf_grant0, perf_grant1 (32-bit grant counts) and perf_wait (32-bit count of cycles any req_valid is high and not ready), all reset to 0, wrapping at 2^32.
REQ-026 YSYX_22041071_ARB_PERF_EN undefined: SHALL have no counters and no perf ports.

Structure
REQ-027 FSM state encodings, master ID constants and AXI size/resp encodings SHALL live in the shared define file.
REQ-028 2-way round-robin selection SHALL be sub-module ysyx_22041071_rr_picker (inputs req[1:0], last_grant; output grant one-hot).

Verification
REQ-029 Only m0 valid, addr 0x8000_0004, len 0 -> ds_ar_valid cycle after accept, ds_addr 0x8000_0004, ds_id 0; one beat 0x1122 -> m0_rsp_valid, last=1.
REQ-030 m0 and m1 valid together after reset -> m0 granted first, m1 granted after m0 last beat plus one idle cycle; ds_id 1.
REQ-031 m1 len 3 burst, 4 beats with resp 0 then last -> m1 sees 4 rsp_valid, rsp_last only on 4th; m0_rsp_valid stays 0.
REQ-032 m0 len 3, m0_kill after beat 1 -> beats 2-4 drained, m0_rsp_valid 0, FSM returns IDLE after beat 4.
REQ-033 reset_n low during DATA beat 2 -> next cycle IDLE, ds_ar_valid 0; later beats produce no rsp_valid.
REQ-034 With YSYX_22041071_ARB_PERF_EN, 3 m0 and 2 m1 grants -> perf_grant0=3, perf_grant1=2.

Source files
------------

// File: rtl/ysyx_22041071_axi_rd_arbiter_pkg.sv
// Shared encodings for the two-master AXI read arbiter: FSM states, master IDs,
// AXI size/resp codes and the owner-to-AXI-ID mapping.
package ysyx_22041071_axi_rd_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_DATA  = 2'd2
   } arb_state_e;

   typedef enum logic {
      MID_IFETCH = 1'b0,
      MID_LOAD   = 1'b1
   } master_id_e;

   typedef enum logic [1:0] {
      AXI_SIZE_1B = 2'b00,
      AXI_SIZE_2B = 2'b01,
      AXI_SIZE_4B = 2'b10,
      AXI_SIZE_8B = 2'b11
   } axi_size_e;

   typedef enum logic [1:0] {
      AXI_RESP_OKAY   = 2'b00,
      AXI_RESP_EXOKAY = 2'b01,
      AXI_RESP_SLVERR = 2'b10,
      AXI_RESP_DECERR = 2'b11
   } axi_resp_e;

   // The AXI ID is simply the owning master number, zero-extended.
   function automatic logic [3:0] owner_to_id(input logic owner);
      return {3'b000, owner};
   endfunction

endpackage

// File: rtl/ysyx_22041071_rr_picker.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to the
// requester that was not granted last.
module ysyx_22041071_rr_picker (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);

   // One-hot grant selection.
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/ysyx_22041071_axi_rd_arbiter.sv
// Read-channel arbiter muxing ifetch (m0) and load (m1) onto one AXI read port,
// one burst in flight. Define YSYX_22041071_ARB_PERF_EN to add grant/wait counters.
module ysyx_22041071_axi_rd_arbiter
   import ysyx_22041071_axi_rd_arbiter_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              m0_req_valid,
   output logic              m0_req_ready,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [LEN_W-1:0]  m0_len,
   input  logic [1:0]        m0_size,
   output logic              m0_rsp_valid,
   output logic [DATA_W-1:0] m0_rsp_data,
   output logic [1:0]        m0_rsp_resp,
   output logic              m0_rsp_last,
   input  logic              m0_kill,
   input  logic              m1_req_valid,
   output logic              m1_req_ready,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [LEN_W-1:0]  m1_len,
   input  logic [1:0]        m1_size,
   output logic              m1_rsp_valid,
   output logic [DATA_W-1:0] m1_rsp_data,
   output logic [1:0]        m1_rsp_resp,
   output logic              m1_rsp_last,
   output logic              ds_ar_valid,
   input  logic              ds_ar_ready,
   output logic [3:0]        ds_id,
   output logic [ADDR_W-1:0] ds_addr,
   output logic [LEN_W-1:0]  ds_len,
   output logic [1:0]        ds_size,
   input  logic              ds_r_valid,
   input  logic [DATA_W-1:0] ds_r_data,
   input  logic [1:0]        ds_r_resp,
   input  logic              ds_r_last
`ifdef YSYX_22041071_ARB_PERF_EN
   ,
   output logic [31:0]       perf_grant0,
   output logic [31:0]       perf_grant1,
   output logic [31:0]       perf_wait
`endif
);

   arb_state_e        state_r;
   arb_state_e        state_nxt_s;
   master_id_e        owner_r;
   logic              kill_r;
   logic              last_grant_r;
   logic [1:0]        grant_s;
   logic              grant_any_s;
   logic              rsp_fire_s;
   logic              ds_ar_valid_r;
   logic [3:0]        ds_id_r;
   logic [ADDR_W-1:0] ds_addr_r;
   logic [LEN_W-1:0]  ds_len_r;
   logic [1:0]        ds_size_r;

   ysyx_22041071_rr_picker u_picker (
      .req        ({m1_req_valid, m0_req_valid}),
      .last_grant (last_grant_r),
      .grant      (grant_s)
   );

   // A grant is only offered while idle; this also zeroes ready in ISSUE/DATA.
   always_comb begin
      grant_any_s  = 1'b0;
      m0_req_ready = 1'b0;
      m1_req_ready = 1'b0;
      if (state_r == ARB_IDLE) begin
         grant_any_s  = (grant_s != 2'b00);
         m0_req_ready = grant_s[0];
         m1_req_ready = grant_s[1];
      end else begin
         grant_any_s  = 1'b0;
      end
   end

   // Next-state logic; the last beat returns to IDLE without granting that cycle.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ARB_IDLE: begin
            if (grant_any_s) state_nxt_s = ARB_ISSUE;
            else             state_nxt_s = ARB_IDLE;
         end
         ARB_ISSUE: begin
            if (ds_ar_ready) state_nxt_s = ARB_DATA;
            else             state_nxt_s = ARB_ISSUE;
         end
         ARB_DATA: begin
            if (ds_r_valid && ds_r_last) state_nxt_s = ARB_IDLE;
            else                         state_nxt_s = ARB_DATA;
         end
         default: state_nxt_s = ARB_IDLE;
      endcase
   end

   // State, ownership and the latched downstream address-channel fields.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r       <= ARB_IDLE;
         owner_r       <= MID_IFETCH;
         last_grant_r  <= 1'b1;
         ds_ar_valid_r <= 1'b0;
         ds_id_r       <= 4'd0;
         ds_addr_r     <= {ADDR_W{1'b0}};
         ds_len_r      <= {LEN_W{1'b0}};
         ds_size_r     <= AXI_SIZE_1B;
      end else begin
         state_r <= state_nxt_s;
         if (grant_any_s) begin
            owner_r       <= grant_s[1] ? MID_LOAD : MID_IFETCH;
            last_grant_r  <= grant_s[1];
            ds_ar_valid_r <= 1'b1;
            ds_id_r       <= owner_to_id(grant_s[1]);
            ds_addr_r     <= grant_s[1] ? m1_addr : m0_addr;
            ds_len_r      <= grant_s[1] ? m1_len  : m0_len;
            ds_size_r     <= grant_s[1] ? m1_size : m0_size;
         end else if ((state_r == ARB_ISSUE) && ds_ar_ready) begin
            ds_ar_valid_r <= 1'b0;
         end
      end
   end

   // Kill flag: only an m0-owned burst in flight can be killed; cleared on leaving it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         kill_r <= 1'b0;
      end else if (state_nxt_s == ARB_IDLE) begin
         kill_r <= 1'b0;
      end else if (m0_kill && (owner_r == MID_IFETCH) &&
                   ((state_r == ARB_ISSUE) || (state_r == ARB_DATA))) begin
         kill_r <= 1'b1;
      end
   end

   assign ds_ar_valid = ds_ar_valid_r;
   assign ds_id       = ds_id_r;
   assign ds_addr     = ds_addr_r;
   assign ds_len      = ds_len_r;
   assign ds_size     = ds_size_r;
   assign rsp_fire_s  = (state_r == ARB_DATA) && ds_r_valid;

   // Same-cycle beat forwarding to the owner; everything else reads as zero.
   always_comb begin
      m0_rsp_valid = 1'b0;
      m0_rsp_data  = {DATA_W{1'b0}};
      m0_rsp_resp  = AXI_RESP_OKAY;
      m0_rsp_last  = 1'b0;
      m1_rsp_valid = 1'b0;
      m1_rsp_data  = {DATA_W{1'b0}};
      m1_rsp_resp  = AXI_RESP_OKAY;
      m1_rsp_last  = 1'b0;
      if (rsp_fire_s && (owner_r == MID_LOAD)) begin
         m1_rsp_valid = 1'b1;
         m1_rsp_data  = ds_r_data;
         m1_rsp_resp  = ds_r_resp;
         m1_rsp_last  = ds_r_last;
      end else if (rsp_fire_s && !kill_r) begin
         m0_rsp_valid = 1'b1;
         m0_rsp_data  = ds_r_data;
         m0_rsp_resp  = ds_r_resp;
         m0_rsp_last  = ds_r_last;
      end else begin
         m0_rsp_valid = 1'b0;
      end
   end

`ifdef YSYX_22041071_ARB_PERF_EN
   logic [31:0] perf_grant0_r;
   logic [31:0] perf_grant1_r;
   logic [31:0] perf_wait_r;

   // Free-running wrap-around counters for grants and stalled request cycles.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         perf_grant0_r <= 32'd0;
         perf_grant1_r <= 32'd0;
         perf_wait_r   <= 32'd0;
      end else begin
         if (m0_req_ready) perf_grant0_r <= perf_grant0_r + 32'd1;
         if (m1_req_ready) perf_grant1_r <= perf_grant1_r + 32'd1;
         if ((m0_req_valid && !m0_req_ready) || (m1_req_valid && !m1_req_ready))
            perf_wait_r <= perf_wait_r + 32'd1;
      end
   end

   assign perf_grant0 = perf_grant0_r;
   assign perf_grant1 = perf_grant1_r;
   assign perf_wait   = perf_wait_r;
`endif

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_arbiter.sv
// Self-checking bench for ysyx_22041071_axi_rd_arbiter: directed scenarios plus
// randomized bursts checked against a transaction-level arbitration model.
module tb_ysyx_22041071_axi_rd_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        m0_req_valid, m0_req_ready, m0_rsp_valid, m0_rsp_last, m0_kill;
   logic [63:0] m0_addr, m0_rsp_data;
   logic [7:0]  m0_len;
   logic [1:0]  m0_size, m0_rsp_resp;
   logic        m1_req_valid, m1_req_ready, m1_rsp_valid, m1_rsp_last;
   logic [63:0] m1_addr, m1_rsp_data;
   logic [7:0]  m1_len;
   logic [1:0]  m1_size, m1_rsp_resp;
   logic        ds_ar_valid, ds_ar_ready, ds_r_valid, ds_r_last;
   logic [3:0]  ds_id;
   logic [63:0] ds_addr, ds_r_data;
   logic [7:0]  ds_len;
   logic [1:0]  ds_size, ds_r_resp;
`ifdef YSYX_22041071_ARB_PERF_EN
   logic [31:0] perf_grant0, perf_grant1, perf_wait;
`endif

   int checks = 0;
   int failures = 0;
   int last_g = 1;
   int g0_cnt = 0;
   int g1_cnt = 0;

   always #5 clk = ~clk;

   ysyx_22041071_axi_rd_arbiter #(.ADDR_W(64), .DATA_W(64), .LEN_W(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
      .m0_addr(m0_addr), .m0_len(m0_len), .m0_size(m0_size),
      .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data),
      .m0_rsp_resp(m0_rsp_resp), .m0_rsp_last(m0_rsp_last), .m0_kill(m0_kill),
      .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
      .m1_addr(m1_addr), .m1_len(m1_len), .m1_size(m1_size),
      .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data),
      .m1_rsp_resp(m1_rsp_resp), .m1_rsp_last(m1_rsp_last),
      .ds_ar_valid(ds_ar_valid), .ds_ar_ready(ds_ar_ready), .ds_id(ds_id),
      .ds_addr(ds_addr), .ds_len(ds_len), .ds_size(ds_size),
      .ds_r_valid(ds_r_valid), .ds_r_data(ds_r_data),
      .ds_r_resp(ds_r_resp), .ds_r_last(ds_r_last)
`ifdef YSYX_22041071_ARB_PERF_EN
      ,
      .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_wait(perf_wait)
`endif
   );

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m0_req_valid = 1'b0; m0_addr = 64'd0; m0_len = 8'd0; m0_size = 2'd0; m0_kill = 1'b0;
      m1_req_valid = 1'b0; m1_addr = 64'd0; m1_len = 8'd0; m1_size = 2'd0;
      ds_ar_ready = 1'b0; ds_r_valid = 1'b0; ds_r_data = 64'd0; ds_r_resp = 2'd0; ds_r_last = 1'b0;
   endtask

   // One complete burst: grant cycle, ISSUE (with optional ar_ready delay), DATA beats.
   // kill_after=k pulses m0_kill before beat k (k=0: during ISSUE); -1 means never.
   task automatic do_burst(input bit v0, input bit v1,
                           input logic [63:0] a0, input logic [63:0] a1,
                           input logic [7:0] l0, input logic [7:0] l1,
                           input logic [1:0] s0, input logic [1:0] s1,
                           input logic [63:0] data_base, input int kill_after,
                           input bit hold_loser, input bit trail, input bit rnd);
      int w, d, beats, gaps;
      bit x0, x1, killed, e0, e1, bl;
      logic [63:0] ea, bd;
      logic [7:0]  el;
      logic [1:0]  es, br;
      w = (v0 && v1) ? ((last_g == 1) ? 0 : 1) : (v0 ? 0 : 1);
      x0 = (w == 0);
      x1 = (w == 1);
      m0_req_valid = v0; m0_addr = a0; m0_len = l0; m0_size = s0;
      m1_req_valid = v1; m1_addr = a1; m1_len = l1; m1_size = s1;
      @(negedge clk);
      checks++; if (m0_req_ready !== x0) begin failures++; $display("FAIL grant_m0_ready: got %b want %b", m0_req_ready, x0); end
      checks++; if (m1_req_ready !== x1) begin failures++; $display("FAIL grant_m1_ready: got %b want %b", m1_req_ready, x1); end
      checks++; if (ds_ar_valid !== 1'b0) begin failures++; $display("FAIL grant_ar_valid: got %b want 0", ds_ar_valid); end
      cyc();
      last_g = w;
      if (w == 0) g0_cnt++; else g1_cnt++;
      ea = x0 ? a0 : a1; el = x0 ? l0 : l1; es = x0 ? s0 : s1;
      if (hold_loser) begin
         if (x0) m0_req_valid = 1'b0; else m1_req_valid = 1'b0;
      end else begin
         m0_req_valid = 1'b0; m1_req_valid = 1'b0;
      end
      killed = 1'b0;
      d = rnd ? int'($urandom_range(0, 3)) : 0;
      for (int i = 0; i <= d; i++) begin
         ds_ar_ready = (i == d);
         m0_kill = (kill_after == 0) && (i == 0);
         if (rnd) begin
            ds_r_valid = 1'($urandom_range(0, 1)); ds_r_data = {$urandom, $urandom};
            ds_r_last = 1'($urandom_range(0, 1));
            if (!hold_loser) begin
               m0_req_valid = 1'($urandom_range(0, 1)); m1_req_valid = 1'($urandom_range(0, 1));
            end
         end
         @(negedge clk);
         checks++; if (ds_ar_valid !== 1'b1) begin failures++; $display("FAIL issue_ar_valid: got %b want 1", ds_ar_valid); end
         checks++; if ({ds_addr, ds_len, ds_size} !== {ea, el, es}) begin failures++; $display("FAIL issue_fields: got %h/%h/%h want %h/%h/%h", ds_addr, ds_len, ds_size, ea, el, es); end
         checks++; if (ds_id !== 4'(w)) begin failures++; $display("FAIL issue_id: got %h want %h", ds_id, 4'(w)); end
         checks++; if ({m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid} !== 4'b0000) begin failures++; $display("FAIL issue_quiet: got %b want 0000", {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid}); end
         cyc();
         if (m0_kill && x0) killed = 1'b1;
      end
      ds_ar_ready = 1'b0; m0_kill = 1'b0; ds_r_valid = 1'b0; ds_r_last = 1'b0;
      if (!hold_loser) begin m0_req_valid = 1'b0; m1_req_valid = 1'b0; end
      beats = int'(el) + 1;
      for (int k = 0; k < beats; k++) begin
         gaps = rnd ? int'($urandom_range(0, 2)) : 0;
         if (kill_after == k && k > 0 && gaps == 0) gaps = 1;
         for (int g = 0; g < gaps; g++) begin
            ds_r_valid = 1'b0;
            m0_kill = (kill_after == k) && (k > 0) && (g == 0);
            if (rnd && !hold_loser) begin
               m0_req_valid = 1'($urandom_range(0, 1)); m1_req_valid = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            checks++; if ({m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid} !== 4'b0000) begin failures++; $display("FAIL data_gap_quiet: got %b want 0000", {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid}); end
            cyc();
            if (m0_kill && x0) killed = 1'b1;
            m0_kill = 1'b0;
         end
         bd = rnd ? {$urandom, $urandom} : data_base + 64'(k);
         br = rnd ? 2'($urandom_range(0, 3)) : 2'b00;
         bl = (k == beats - 1);
         ds_r_valid = 1'b1; ds_r_data = bd; ds_r_resp = br; ds_r_last = bl;
         @(negedge clk);
         e0 = x0 && !killed;
         e1 = x1;
         checks++; if ({m0_rsp_valid, m0_rsp_data, m0_rsp_resp, m0_rsp_last} !== (e0 ? {1'b1, bd, br, bl} : 68'd0)) begin failures++; $display("FAIL beat%0d_m0_rsp: got %b/%h/%h/%b want valid %b data %h", k, m0_rsp_valid, m0_rsp_data, m0_rsp_resp, m0_rsp_last, e0, bd); end
         checks++; if ({m1_rsp_valid, m1_rsp_data, m1_rsp_resp, m1_rsp_last} !== (e1 ? {1'b1, bd, br, bl} : 68'd0)) begin failures++; $display("FAIL beat%0d_m1_rsp: got %b/%h/%h/%b want valid %b data %h", k, m1_rsp_valid, m1_rsp_data, m1_rsp_resp, m1_rsp_last, e1, bd); end
         checks++; if ({m0_req_ready, m1_req_ready} !== 2'b00) begin failures++; $display("FAIL beat%0d_ready: got %b want 00", k, {m0_req_ready, m1_req_ready}); end
         cyc();
      end
      ds_r_valid = 1'b0; ds_r_last = 1'b0;
      if (!hold_loser) begin m0_req_valid = 1'b0; m1_req_valid = 1'b0; end
      if (trail) begin
         // Idle cycle with a stray beat and an m0_kill, both of which must be ignored.
         m0_kill = 1'b1; ds_r_valid = 1'b1; ds_r_last = 1'b1;
         @(negedge clk);
         checks++; if ({ds_ar_valid, m0_rsp_valid, m1_rsp_valid, m0_req_ready, m1_req_ready} !== 5'b00000) begin failures++; $display("FAIL idle_quiet: got %b want 00000", {ds_ar_valid, m0_rsp_valid, m1_rsp_valid, m0_req_ready, m1_req_ready}); end
         cyc();
         m0_kill = 1'b0; ds_r_valid = 1'b0; ds_r_last = 1'b0;
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      reset_n = 1'b0;
      cyc(); cyc();
      @(negedge clk);
      checks++; if ({ds_ar_valid, ds_id, ds_addr, ds_len, ds_size} !== 79'd0) begin failures++; $display("FAIL reset_ds: got %b/%h/%h/%h/%h want all 0", ds_ar_valid, ds_id, ds_addr, ds_len, ds_size); end
      checks++; if ({m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid} !== 4'b0000) begin failures++; $display("FAIL reset_masters: got %b want 0000", {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid}); end
      reset_n = 1'b1;
      last_g = 1; g0_cnt = 0; g1_cnt = 0;
      cyc();
   endtask

   task automatic test_single_m0();
      do_burst(1'b1, 1'b0, 64'h8000_0004, 64'd0, 8'd0, 8'd0, 2'b10, 2'b00, 64'h1122, -1, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_tie();
      do_burst(1'b1, 1'b1, 64'h8000_1000, 64'h9000_2000, 8'd1, 8'd0, 2'b11, 2'b10, 64'hA0, -1, 1'b1, 1'b0, 1'b0);
      do_burst(1'b0, 1'b1, 64'd0, 64'h9000_2000, 8'd0, 8'd0, 2'b00, 2'b10, 64'hB0, -1, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_m1_burst();
      do_burst(1'b0, 1'b1, 64'd0, 64'h1234_5678, 8'd0, 8'd3, 2'b00, 2'b11, 64'hC0, -1, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_kill();
      do_burst(1'b1, 1'b0, 64'h8000_0040, 64'd0, 8'd3, 8'd0, 2'b11, 2'b00, 64'hD0, 1, 1'b0, 1'b1, 1'b0);
      do_burst(1'b1, 1'b0, 64'h8000_0080, 64'd0, 8'd0, 8'd0, 2'b11, 2'b00, 64'hE0, -1, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid();
      m0_req_valid = 1'b1; m0_addr = 64'h8000_0100; m0_len = 8'd3; m0_size = 2'b11;
      cyc();
      m0_req_valid = 1'b0; ds_ar_ready = 1'b1;
      cyc();
      ds_ar_ready = 1'b0; ds_r_valid = 1'b1; ds_r_data = 64'h55; ds_r_last = 1'b0;
      @(negedge clk);
      checks++; if ({m0_rsp_valid, m0_rsp_data} !== {1'b1, 64'h55}) begin failures++; $display("FAIL rstmid_beat1: got %b/%h want 1/55", m0_rsp_valid, m0_rsp_data); end
      cyc();
      reset_n = 1'b0; ds_r_data = 64'h66;
      cyc();
      reset_n = 1'b1; last_g = 1; g0_cnt = 0; g1_cnt = 0;
      for (int b = 3; b <= 4; b++) begin
         ds_r_valid = 1'b1; ds_r_data = 64'(b); ds_r_last = (b == 4);
         @(negedge clk);
         checks++; if ({ds_ar_valid, m0_rsp_valid, m1_rsp_valid} !== 3'b000) begin failures++; $display("FAIL rstmid_beat%0d: got %b want 000", b, {ds_ar_valid, m0_rsp_valid, m1_rsp_valid}); end
         cyc();
      end
      ds_r_valid = 1'b0; ds_r_last = 1'b0;
   endtask

   task automatic test_random();
      int r, ka;
      for (int n = 0; n < 40; n++) begin
         r = int'($urandom_range(1, 3));
         ka = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1;
         do_burst(r[0], r[1], {$urandom, $urandom}, {$urandom, $urandom},
                  8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  64'd0, ka, 1'b0, 1'b1, 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_single_m0();
      test_tie();
      test_m1_burst();
      test_kill();
      test_reset_mid();
`ifdef YSYX_22041071_ARB_PERF_EN
      do_burst(1'b1, 1'b0, 64'h10, 64'd0, 8'd0, 8'd0, 2'b11, 2'b00, 64'h1, -1, 1'b0, 1'b1, 1'b0);
      do_burst(1'b1, 1'b1, 64'h20, 64'h30, 8'd0, 8'd0, 2'b11, 2'b11, 64'h2, -1, 1'b1, 1'b0, 1'b0);
      do_burst(1'b0, 1'b1, 64'h20, 64'h30, 8'd0, 8'd0, 2'b11, 2'b11, 64'h3, -1, 1'b0, 1'b1, 1'b0);
      do_burst(1'b1, 1'b1, 64'h40, 64'h50, 8'd0, 8'd0, 2'b11, 2'b11, 64'h4, -1, 1'b1, 1'b0, 1'b0);
      do_burst(1'b1, 1'b0, 64'h40, 64'h50, 8'd0, 8'd0, 2'b11, 2'b11, 64'h5, -1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      checks++; if ({perf_grant0, perf_grant1} !== {32'(g0_cnt), 32'(g1_cnt)}) begin failures++; $display("FAIL perf_grants: got %0d/%0d want %0d/%0d", perf_grant0, perf_grant1, g0_cnt, g1_cnt); end
      cyc();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
